// File: rtl/serial_link_stripe_pkg.sv
// Shared types and width helpers for the serial link TX striping block.
package serial_link_stripe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int chan_w(input int lanes);
    return 2 * lanes;
  endfunction

  // Beat base index and ranks range over 0..NumChannels inclusive.
  function automatic int beat_w(input int chans);
    return $clog2(chans + 1);
  endfunction

endpackage

// File: rtl/serial_link_stripe_rank.sv
// Per-channel rank (count of enabled channels below it) and total popcount of a mask.
module serial_link_stripe_rank
  import serial_link_stripe_pkg::*;
#(
  parameter int NumChannels = 4,
  parameter int RankW       = beat_w(NumChannels)
) (
  input  logic [NumChannels-1:0]            mask_i,
  output logic [NumChannels-1:0][RankW-1:0] rank_o,
  output logic [RankW-1:0]                  pop_o
);

  always_comb begin
    int acc;
    acc    = 0;
    rank_o = '0;
    for (int i = 0; i < NumChannels; i++) begin
      rank_o[i] = RankW'(acc);
      acc += int'(mask_i[i]);
    end
    pop_o = RankW'(acc);
  end

endmodule

// File: rtl/serial_link_tx_stripe.sv
// Stripes a flit across the enabled link channels, one beat per handshake.
// Optional completed-flit counter: define SERIAL_LINK_STRIPE_PERF_EN.
module serial_link_tx_stripe
  import serial_link_stripe_pkg::*;
#(
  parameter  int NumChannels = 4,
  parameter  int NumLanes    = 8,
  localparam int ChanW       = chan_w(NumLanes)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumChannels*ChanW-1:0]        data_i,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [NumChannels-1:0]              chan_en_i,
  output logic [NumChannels-1:0][ChanW-1:0]   data_o,
  output logic [NumChannels-1:0]              chan_vld_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic                                last_o,
  output logic [31:0]                         perf_flits_o
);

  localparam int BW = beat_w(NumChannels);

  state_e                             state_p0, nxt_state;
  logic [NumChannels*ChanW-1:0]       flit_p0, nxt_flit;
  logic [NumChannels-1:0]             mask_p0, nxt_mask;
  logic [BW-1:0]                      base_p0, nxt_base;
  logic [BW-1:0]                      pop_p0, pop_nx;
  logic [NumChannels-1:0][BW-1:0]     rank_nx;
  logic [NumChannels-1:0][ChanW-1:0]  data_nx;
  logic [NumChannels-1:0]             vld_nx;
  logic                               last_nx;
  logic                               accept, adv;

  // A new flit may only enter while idle or as the current final beat leaves.
  assign ready_o = !rst_i && (chan_en_i != '0) &&
                   ((state_p0 == IDLE) || (last_o && ready_i));
  assign valid_o = (state_p0 == SEND);
  assign accept  = valid_i && ready_o;
  assign adv     = valid_o && ready_i;

  always_comb begin
    nxt_state = state_p0;
    nxt_flit  = flit_p0;
    nxt_mask  = mask_p0;
    nxt_base  = base_p0;
    if (accept) begin
      nxt_state = SEND;
      nxt_flit  = data_i;
      nxt_mask  = chan_en_i;
      nxt_base  = '0;
    end else if (adv) begin
      if (last_o) nxt_state = IDLE;
      else        nxt_base  = base_p0 + pop_p0;
    end
  end

  serial_link_stripe_rank #(
    .NumChannels (NumChannels),
    .RankW       (BW)
  ) u_rank (
    .mask_i (nxt_mask),
    .rank_o (rank_nx),
    .pop_o  (pop_nx)
  );

  // Stage p0: beat contents for the upcoming cycle, built from the next state.
  always_comb begin
    data_nx = '0;
    vld_nx  = '0;
    last_nx = 1'b0;
    if (nxt_state == SEND) begin
      for (int c = 0; c < NumChannels; c++) begin
        if (nxt_mask[c]) begin
          for (int k = 0; k < NumChannels; k++) begin
            if (int'(nxt_base) + int'(rank_nx[c]) == k) begin
              data_nx[c] = nxt_flit[k*ChanW +: ChanW];
              vld_nx[c]  = 1'b1;
            end
          end
        end
      end
      last_nx = (int'(nxt_base) + int'(pop_nx) >= NumChannels);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p0   <= IDLE;
      mask_p0    <= '0;
      base_p0    <= '0;
      pop_p0     <= '0;
      data_o     <= '0;
      chan_vld_o <= '0;
      last_o     <= 1'b0;
    end else begin
      state_p0   <= nxt_state;
      mask_p0    <= nxt_mask;
      base_p0    <= nxt_base;
      pop_p0     <= pop_nx;
      data_o     <= data_nx;
      chan_vld_o <= vld_nx;
      last_o     <= last_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    flit_p0 <= nxt_flit;
  end

`ifdef SERIAL_LINK_STRIPE_PERF_EN
  logic [31:0] perf_p0;

  always_ff @(posedge clk_i) begin
    if (rst_i)              perf_p0 <= '0;
    else if (adv && last_o) perf_p0 <= perf_p0 + 32'd1;
  end

  assign perf_flits_o = perf_p0;
`else
  assign perf_flits_o = '0;
`endif

endmodule

// File: tb/tb_serial_link_tx_stripe.sv
// Directed bench for serial_link_tx_stripe with a flit-level beat-queue model.
module tb_serial_link_tx_stripe;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [63:0]      data_i;
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       chan_en_i;
  logic [3:0][15:0] data_o;
  logic [3:0]       chan_vld_o;
  logic             valid_o;
  logic             ready_i;
  logic             last_o;
  logic [31:0]      perf_flits_o;

  serial_link_tx_stripe #(
    .NumChannels (4),
    .NumLanes    (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .chan_en_i    (chan_en_i),
    .data_o       (data_o),
    .chan_vld_o   (chan_vld_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .last_o       (last_o),
    .perf_flits_o (perf_flits_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  v;
    logic        l;
  } beat_t;

  beat_t       q[$];
  int          errors = 0;
  int          checks = 0;
  logic        started = 1'b0;
  logic [31:0] perf_exp = '0;
  logic        exp_rdy;

  logic        pin_on = 1'b0;
  logic [63:0] pin_d;
  logic [3:0]  pin_v;
  logic        pin_l;
  logic        pin_vo;

  localparam logic [63:0] F1 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] F2 = 64'h8888_7777_6666_5555;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expand one accepted flit into its full list of beats.
  task automatic build(input logic [63:0] flit, input logic [3:0] mask);
    int p;
    int b;
    int r;
    beat_t bt;
    p = $countones(mask);
    b = 0;
    while (b < 4) begin
      bt.d = '0;
      bt.v = '0;
      r = 0;
      for (int c = 0; c < 4; c++) begin
        if (mask[c]) begin
          if (b + r < 4) begin
            bt.d[c*16 +: 16] = flit[(b+r)*16 +: 16];
            bt.v[c] = 1'b1;
          end
          r++;
        end
      end
      bt.l = (b + p >= 4);
      q.push_back(bt);
      b += p;
    end
  endtask

  always @(negedge clk_i) begin
    if (started) begin
      exp_rdy = !rst_i && (chan_en_i != 4'b0) && ((q.size() == 0) || (q[0].l && ready_i));
      chk("ready_o", 64'(ready_o), 64'(exp_rdy));
      chk("valid_o", 64'(valid_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("data_o", data_o, q[0].d);
        chk("chan_vld_o", 64'(chan_vld_o), 64'(q[0].v));
        chk("last_o", 64'(last_o), 64'(q[0].l));
      end
      chk("perf_flits_o", 64'(perf_flits_o), 64'(perf_exp));
      if (pin_on) begin
        chk("pin_valid", 64'(valid_o), 64'(pin_vo));
        chk("pin_data", data_o, pin_d);
        chk("pin_vld", 64'(chan_vld_o), 64'(pin_v));
        chk("pin_last", 64'(last_o), 64'(pin_l));
      end
      if (rst_i) begin
        q.delete();
        perf_exp = '0;
      end else begin
        if (q.size() != 0 && ready_i) begin
`ifdef SERIAL_LINK_STRIPE_PERF_EN
          if (q[0].l) perf_exp = perf_exp + 32'd1;
`endif
          void'(q.pop_front());
        end
        if (valid_i && exp_rdy) build(data_i, chan_en_i);
      end
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
    pin_on = 1'b0;
  endtask

  task automatic pin(input logic [63:0] d, input logic [3:0] v, input logic l, input logic vo);
    pin_d  = d;
    pin_v  = v;
    pin_l  = l;
    pin_vo = vo;
    pin_on = 1'b1;
  endtask

  // Present a flit for one edge (caller ensures ready_o is high).
  task automatic send(input logic [63:0] flit, input logic [3:0] mask);
    data_i    = flit;
    chan_en_i = mask;
    valid_i   = 1'b1;
    cyc();
    valid_i   = 1'b0;
  endtask

  initial begin
    rst_i     = 1'b1;
    data_i    = '0;
    valid_i   = 1'b0;
    chan_en_i = 4'b1111;
    ready_i   = 1'b1;
    cyc();
    started = 1'b1;
    pin(64'h0, 4'b0, 1'b0, 1'b0);
    cyc();
    pin(64'h0, 4'b0, 1'b0, 1'b0);
    cyc();
    rst_i = 1'b0;
    cyc();

    // All four channels: single beat.
    send(F1, 4'b1111);
    pin(F1, 4'b1111, 1'b1, 1'b1);
    cyc();
    cyc();

    // Alternate channels; mask change mid-flit must be ignored.
    send(F1, 4'b0101);
    chan_en_i = 4'b1111;
    pin(64'h0000_2222_0000_1111, 4'b0101, 1'b0, 1'b1);
    cyc();
    pin(64'h0000_4444_0000_3333, 4'b0101, 1'b1, 1'b1);
    cyc();
    cyc();

    // Three channels: second beat only partially filled.
    send(F1, 4'b0111);
    pin(64'h0000_3333_2222_1111, 4'b0111, 1'b0, 1'b1);
    cyc();
    pin(64'h0000_0000_0000_4444, 4'b0001, 1'b1, 1'b1);
    cyc();
    cyc();

    // No channels enabled: flit must wait, then go out one chunk per beat.
    data_i    = F1;
    chan_en_i = 4'b0000;
    valid_i   = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    chan_en_i = 4'b0001;
    cyc();
    valid_i = 1'b0;
    pin(64'h1111, 4'b0001, 1'b0, 1'b1);
    cyc();
    pin(64'h2222, 4'b0001, 1'b0, 1'b1);
    cyc();
    pin(64'h3333, 4'b0001, 1'b0, 1'b1);
    cyc();
    pin(64'h4444, 4'b0001, 1'b1, 1'b1);
    cyc();
    cyc();

    // Backpressure at beat1, then back-to-back second flit on the final beat.
    send(F1, 4'b0001);
    pin(64'h1111, 4'b0001, 1'b0, 1'b1);
    cyc();
    ready_i = 1'b0;
    pin(64'h2222, 4'b0001, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      pin(64'h2222, 4'b0001, 1'b0, 1'b1);
    end
    cyc();
    ready_i = 1'b1;
    pin(64'h2222, 4'b0001, 1'b0, 1'b1);
    cyc();
    pin(64'h3333, 4'b0001, 1'b0, 1'b1);
    cyc();
    data_i    = F2;
    chan_en_i = 4'b0011;
    valid_i   = 1'b1;
    pin(64'h4444, 4'b0001, 1'b1, 1'b1);
    cyc();
    valid_i = 1'b0;
    pin(64'h0000_0000_6666_5555, 4'b0011, 1'b0, 1'b1);
    cyc();
    pin(64'h0000_0000_8888_7777, 4'b0011, 1'b1, 1'b1);
    cyc();
    cyc();

    // Reset during beat1 aborts the flit.
    send(F1, 4'b0001);
    pin(64'h1111, 4'b0001, 1'b0, 1'b1);
    cyc();
    rst_i = 1'b1;
    pin(64'h2222, 4'b0001, 1'b0, 1'b1);
    cyc();
    rst_i = 1'b0;
    pin(64'h0, 4'b0, 1'b0, 1'b0);
    cyc();
    pin(64'h0, 4'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_link_tx_stripe.md
SERIAL_LINK_TX_STRIPE -- requirements
Module: serial_link_tx_stripe

Interface
REQ-001 SHALL have parameter NumChannels, default 4, number of physical link channels (>=1).
REQ-002 SHALL have parameter NumLanes, default 8, DDR lanes per channel; chunk width ChanW = 2*NumLanes bits.
REQ-003 SHALL have port clk_i  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port data_i  in  NumChannels*ChanW  flit; chunk k = data_i[k*ChanW +: ChanW].
REQ-006 SHALL have ports valid_i in 1 / ready_o out 1  flit-input handshake.
REQ-007 SHALL have port chan_en_i  in  NumChannels  enabled-channel mask.
REQ-008 SHALL have port data_o  out  NumChannels x ChanW  per-channel chunk.
REQ-009 SHALL have port chan_vld_o  out  NumChannels  channels carrying a real chunk this beat.
REQ-010 SHALL have ports valid_o out 1 / ready_i in 1 / last_o out 1  beat handshake; last_o marks final beat.
REQ-011 SHALL have port perf_flits_o  out  32  completed-flit count (see Configuration).

Function
REQ-012 SHALL use states IDLE and SEND; IDLE->SEND on valid_i&&ready_o; SEND->IDLE on final-beat handshake with no new flit accepted.
REQ-013 SHALL assert ready_o in IDLE when chan_en_i!=0, and in SEND only when last_o&&valid_o&&ready_i&&chan_en_i!=0 (back-to-back acceptance).
REQ-014 SHALL latch data_i and chan_en_i on acceptance; chan_en_i changes mid-flit SHALL be ignored until next acceptance.
REQ-015 SHALL present first beat in cycle after acceptance (registered outputs, latency 1), valid_o high throughout SEND.
REQ-016 SHALL, per beat with base index b and P = popcount(latched mask), drive enabled channel of rank r (ascending index) with chunk b+r if b+r<NumChannels, else zero with chan_vld_o bit low; disabled channels zero, chan_vld_o low.
REQ-017 SHALL advance b by P on each valid_o&&ready_i; b starts 0; last_o = (b+P >= NumChannels); beats per flit = ceil(NumChannels/P).
REQ-018 SHALL hold data_o, chan_vld_o, last_o stable while valid_o&&!ready_i.
REQ-019 SHALL size b as clog2(NumChannels+1) bits, with no wrap within a flit.
REQ-020 SHALL keep ready_o low while chan_en_i==0 in IDLE; no flit lost.

Reset
REQ-021 SHALL on rst_i drive state IDLE, b=0, valid_o=0, ready_o=0, last_o=0, data_o=0, chan_vld_o=0, perf_flits_o=0, effective next cycle.
REQ-022 SHALL discard an in-flight flit on reset mid-operation; no beat of it emitted after reset deasserts.

Configuration
REQ-023 SHALL with SERIAL_LINK_STRIPE_PERF_EN defined increment perf_flits_o by 1 on each final-beat handshake, wrapping at 2^32.
REQ-024 SHALL without SERIAL_LINK_STRIPE_PERF_EN tie perf_flits_o to 0 and instantiate no counter.

Structure
REQ-025 SHALL place state enum and ChanW/beat-index width helpers in package serial_link_stripe_pkg.
REQ-026 SHALL implement rank computation (mask -> per-channel prefix popcount) in sub-module serial_link_stripe_rank.

Verification (NumChannels=4, NumLanes=8, flit 0x4444_3333_2222_1111)
REQ-027 mask 1111, ready_i=1 -> one beat next cycle: ch0..3=1111,2222,3333,4444, chan_vld_o=1111, last_o=1.
REQ-028 mask 0101 -> beat0 ch0=1111 ch2=2222; beat1 ch0=3333 ch2=4444 last_o=1; ch1/ch3 zero.
REQ-029 mask 0111 -> beat0 ch0..2=1111,2222,3333; beat1 ch0=4444, chan_vld_o=0001, last_o=1.
REQ-030 mask 0000 -> ready_o stays 0 for 10 cycles; then mask 0001 -> flit accepted, 4 beats.
REQ-031 mask 0001, ready_i=0 for 5 cycles at beat1 -> outputs frozen at 2222; back-to-back second flit accepted on final beat, no idle cycle.
REQ-032 rst_i during beat1 -> all outputs 0 next cycle; perf_flits_o unchanged by aborted flit (PERF_EN on).
